// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID decoupling queue.
// valid/ready: a transfer happens on a rising edge where valid && ready are both high; the flush input PC_src cancels any transfer in that cycle.
interface if_id_queue_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          valid_F;
    logic [31:0]   instruction_F;
    logic [31:0]   PC_F;
    logic          ready_F;
    logic          PC_src;
    logic          valid_D;
    logic [31:0]   instruction_D;
    logic [31:0]   PC_D;
    logic [31:0]   PC_plus4_D;
    logic          ready_D;
    logic [CW-1:0] count;

    modport master (
        output valid_F, instruction_F, PC_F, PC_src, ready_D,
        input  ready_F, valid_D, instruction_D, PC_D, PC_plus4_D, count
    );

    modport slave (
        input  valid_F, instruction_F, PC_F, PC_src, ready_D,
        output ready_F, valid_D, instruction_D, PC_D, PC_plus4_D, count
    );
endinterface

// File: rtl/if_id_queue.sv
// Circular FIFO between fetch and decode; PC_src flushes all buffered wrong-path entries.
// Occupancy lives in count_q so full/empty never depend on pointer comparison.
module if_id_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    if_id_queue_if.slave      bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   pc_mem_d    [DEPTH];

    logic not_empty;
    logic not_full;
    logic push;
    logic pop;

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != CW'(DEPTH));
    assign push      = bus.valid_F && not_full && !bus.PC_src;
    assign pop       = not_empty && bus.ready_D && !bus.PC_src;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        if (bus.PC_src) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = bus.instruction_F;
                pc_mem_d[wr_ptr_q]    = bus.PC_F;
                wr_ptr_d              = PW'(wr_ptr_q + 1'b1);
            end
            if (pop) begin
                rd_ptr_d = PW'(rd_ptr_q + 1'b1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push && !pop) begin
                count_d = CW'(count_q + 1'b1);
            end else if (pop && !push) begin
                count_d = CW'(count_q - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is never reset; entries are only read while count_q says they are live.
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

    always_comb begin
        bus.ready_F       = not_full;
        bus.valid_D       = not_empty;
        bus.count         = count_q;
        bus.instruction_D = NOP_INSTR;
        bus.PC_D          = 32'h0000_0000;
        if (not_empty) begin
            bus.instruction_D = instr_mem_q[rd_ptr_q];
            bus.PC_D          = pc_mem_q[rd_ptr_q];
        end
        bus.PC_plus4_D = bus.PC_D + 32'd4;
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard: each entry is {instruction, PC}, oldest at the front.
    logic [63:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                         input bit rd, input bit src);
        bus.valid_F       = v;
        bus.instruction_F = instr;
        bus.PC_F          = pc;
        bus.ready_D       = rd;
        bus.PC_src        = src;
    endtask

    // Compare DUT outputs with the model, then advance the model by one edge using the driven inputs.
    task automatic cycle(input bit chk);
        logic [31:0] e_instr, e_pc;
        bit do_push, do_pop;
        if (chk) begin
            e_instr = NOP;
            e_pc    = 32'h0;
            if (exp_q.size() != 0) begin
                e_instr = exp_q[0][63:32];
                e_pc    = exp_q[0][31:0];
            end
            check("valid_D",       32'(bus.valid_D), 32'(exp_q.size() != 0));
            check("instruction_D", bus.instruction_D, e_instr);
            check("PC_D",          bus.PC_D, e_pc);
            check("PC_plus4_D",    bus.PC_plus4_D, e_pc + 32'd4);
            check("count",         32'(bus.count), 32'(exp_q.size()));
            check("ready_F",       32'(bus.ready_F), 32'(exp_q.size() < DEPTH));
        end
        if (rst || bus.PC_src) begin
            exp_q.delete();
        end else begin
            do_push = bus.valid_F && (exp_q.size() < DEPTH);
            do_pop  = (exp_q.size() > 0) && bus.ready_D;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({bus.instruction_F, bus.PC_F});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 32'h1111_1111, 32'h100, 1'b0, 1'b0);

        // Reset held two cycles with valid_F high: nothing captured.
        cycle(1'b0);
        cycle(1'b1);
        check("rst_valid_D",    32'(bus.valid_D), 32'd0);
        check("rst_PC_plus4_D", bus.PC_plus4_D, 32'd4);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1);

        // Fill and stall.
        drive(1'b1, 32'h2008_0005, 32'h0, 1'b0, 1'b0);
        cycle(1'b1);
        drive(1'b1, 32'h2009_0003, 32'h4, 1'b0, 1'b0);
        cycle(1'b1);
        check("full_count",   32'(bus.count), 32'd2);
        check("full_ready_F", 32'(bus.ready_F), 32'd0);
        check("full_head",    bus.instruction_D, 32'h2008_0005);
        drive(1'b1, 32'hDEAD_BEEF, 32'h8, 1'b0, 1'b0);
        cycle(1'b1);
        cycle(1'b1);
        check("stall_head_pc", bus.PC_D, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1);
        check("pop1_pc", bus.PC_D, 32'h4);
        cycle(1'b1);
        check("pop2_empty", 32'(bus.valid_D), 32'd0);

        // Streaming: PC_D trails PC_F by one cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, $urandom, 32'(i * 4), 1'b1, 1'b0);
            cycle(1'b1);
            check("stream_pc", bus.PC_D, 32'(i * 4));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1);

        // Flush with simultaneous push and pop at count 2.
        drive(1'b1, 32'hAAAA_0001, 32'h10, 1'b0, 1'b0);
        cycle(1'b1);
        drive(1'b1, 32'hAAAA_0002, 32'h14, 1'b0, 1'b0);
        cycle(1'b1);
        drive(1'b1, 32'hBAD0_0000, 32'h18, 1'b1, 1'b1);
        cycle(1'b1);
        check("flush_valid_D", 32'(bus.valid_D), 32'd0);
        check("flush_ready_F", 32'(bus.ready_F), 32'd1);
        drive(1'b1, 32'hC0DE_0040, 32'h40, 1'b0, 1'b0);
        cycle(1'b1);
        check("post_flush_pc", bus.PC_D, 32'h40);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1);

        // Address wrap on PC_plus4_D.
        drive(1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cycle(1'b1);
        check("wrap_pc_plus4", bus.PC_plus4_D, 32'h0000_0000);

        // Reset mid-operation together with PC_src and valid_F.
        drive(1'b1, 32'h5555_0000, 32'h50, 1'b0, 1'b0);
        cycle(1'b1);
        rst = 1'b1;
        drive(1'b1, 32'h6666_0000, 32'h60, 1'b1, 1'b1);
        cycle(1'b1);
        check("midrst_count", 32'(bus.count), 32'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0);
            cycle(1'b1);
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
